// File: rtl/sys_rst_seq.sv
// Board-level reset sequencer: pulses the PLL reset, qualifies lock, then releases
// CH_NUM active-low domain resets in staggered order, re-sequencing on lock loss.
module sys_rst_seq #(
    parameter int U_DLY        = 1,
    parameter int CH_NUM       = 4,
    parameter int CNT_W        = 32,
    parameter int PLL_RST_DLY  = 100,
    parameter int PLL_RST_LEN  = 1000,
    parameter int LOCK_TIMEOUT = 6250000,
    parameter int LOCK_STABLE  = 6250000,
    parameter int STAGE_GAP    = 1000,
    parameter int LOCK_FILT    = 8
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              soft_rst_en,
    output logic              rst_pll,
    output logic [CH_NUM-1:0] rst_out_n,
    output logic              seq_done,
    output logic [7:0]        lock_lost_cnt,
    output logic [2:0]        seq_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5
    } state_t;

    // Limits are compared with >= against holding counters, so the last count
    // before a transition is LIMIT-1 for the length-type timers.
    localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(PLL_RST_DLY);
    localparam logic [CNT_W-1:0] LEN_LIM  = CNT_W'(PLL_RST_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LIM  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] FILT_LIM = CNT_W'(LOCK_FILT);

    if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
        $error("sys_rst_seq: CH_NUM must be 1..16");
    end
    if (U_DLY < 0) begin : g_bad_u_dly
        $error("sys_rst_seq: U_DLY must be non-negative");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    function automatic logic [CNT_W-1:0] stage_at(input int k);
        return CNT_W'(k * STAGE_GAP);
    endfunction

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [CNT_W-1:0]   filt;
    logic [CNT_W-1:0]   filt_nx;
    logic [CNT_W-1:0]   filt_inc;
    logic [CH_NUM-1:0]  rstn_nx;
    logic [7:0]         llc_nx;
    logic               lock_meta;
    logic               lock_s;
    logic               lock_loss;

    // Stage 0: two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    assign filt_inc  = lock_s ? '0 : sat_inc(filt);
    assign lock_loss = !lock_s && (filt_inc >= FILT_LIM);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        filt_nx  = '0;
        rstn_nx  = rst_out_n;
        llc_nx   = lock_lost_cnt;
        case (state)
            IDLE: begin
                rstn_nx = '0;
                if (cnt >= DLY_LIM) begin
                    state_nx = PLL_RST;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            PLL_RST: begin
                rstn_nx = '0;
                if (cnt >= LEN_LIM) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            WAIT_LOCK: begin
                rstn_nx = '0;
                if (lock_s) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt >= TMO_LIM) begin
                    state_nx = PLL_RST;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            STABLE: begin
                rstn_nx = '0;
                if (soft_rst_en || !lock_s) begin
                    cnt_nx = '0;
                end else if (cnt >= STB_LIM) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                    rstn_nx  = CH_NUM'(1);
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            RELEASE, RUN: begin
                // Lock loss outranks a coincident soft reset request
                if (lock_loss) begin
                    state_nx = PLL_RST;
                    cnt_nx   = '0;
                    rstn_nx  = '0;
                    llc_nx   = sat_inc8(lock_lost_cnt);
                end else if (soft_rst_en) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                    rstn_nx  = '0;
                end else begin
                    filt_nx = filt_inc;
                    if (state == RELEASE) begin
                        cnt_nx = sat_inc(cnt);
                        for (int k = 1; k < CH_NUM; k++) begin
                            if (cnt_nx >= stage_at(k)) rstn_nx[k] = 1'b1;
                        end
                        if (&rstn_nx) state_nx = RUN;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                rstn_nx  = '0;
            end
        endcase
    end

    // Stage 1: state, timers and registered outputs
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            filt          <= '0;
            rst_pll       <= 1'b0;
            rst_out_n     <= '0;
            seq_done      <= 1'b0;
            lock_lost_cnt <= 8'd0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            filt          <= filt_nx;
            rst_pll       <= (state_nx == PLL_RST);
            rst_out_n     <= rstn_nx;
            seq_done      <= (state_nx == RUN);
            lock_lost_cnt <= llc_nx;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Directed vector bench for sys_rst_seq with small timing parameters
// (CH_NUM=3, PLL_RST_DLY=4, PLL_RST_LEN=8, LOCK_TIMEOUT=64, LOCK_STABLE=16, STAGE_GAP=5, LOCK_FILT=3).
module tb_sys_rst_seq;

    localparam int CH = 3;

    logic          clk_sys = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          soft_rst_en;
    logic          rst_pll;
    logic [CH-1:0] rst_out_n;
    logic          seq_done;
    logic [7:0]    lock_lost_cnt;
    logic [2:0]    seq_state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    sys_rst_seq #(
        .U_DLY(1), .CH_NUM(CH), .CNT_W(32), .PLL_RST_DLY(4), .PLL_RST_LEN(8),
        .LOCK_TIMEOUT(64), .LOCK_STABLE(16), .STAGE_GAP(5), .LOCK_FILT(3)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .soft_rst_en(soft_rst_en),
        .rst_pll(rst_pll), .rst_out_n(rst_out_n), .seq_done(seq_done),
        .lock_lost_cnt(lock_lost_cnt), .seq_state(seq_state)
    );

    typedef struct {
        int         adv;
        logic       lk;
        logic       sf;
        logic       pll;
        logic [2:0] rn;
        logic       dn;
        logic [7:0] llc;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int adv, input logic lk, input logic sf, input logic pll,
                       input logic [2:0] rn, input logic dn, input logic [7:0] llc,
                       input logic [2:0] st);
        vec_t v;
        v.adv = adv; v.lk = lk; v.sf = sf; v.pll = pll;
        v.rn = rn; v.dn = dn; v.llc = llc; v.st = st;
        tbl.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic chk(input string tag, input int idx, input logic pll, input logic [2:0] rn,
                       input logic dn, input logic [7:0] llc, input logic [2:0] st);
        cmp({tag, ".rst_pll"}, idx, rst_pll, pll);
        cmp({tag, ".rst_out_n"}, idx, rst_out_n, rn);
        cmp({tag, ".seq_done"}, idx, seq_done, dn);
        cmp({tag, ".lock_lost_cnt"}, idx, lock_lost_cnt, llc);
        cmp({tag, ".seq_state"}, idx, seq_state, st);
    endtask

    initial begin
        // adv, locked, soft | rst_pll, rst_out_n, seq_done, lock_lost_cnt, state
        // power-up with lock tied high (edge numbers after rst release)
        add(4, 1, 0, 0, 3'b000, 0, 0, 0);   // e4
        add(1, 1, 0, 1, 3'b000, 0, 0, 1);   // e5
        add(7, 1, 0, 1, 3'b000, 0, 0, 1);   // e12
        add(1, 1, 0, 0, 3'b000, 0, 0, 2);   // e13
        add(1, 1, 0, 0, 3'b000, 0, 0, 3);   // e14
        add(15, 1, 0, 0, 3'b000, 0, 0, 3);  // e29
        add(1, 1, 0, 0, 3'b001, 0, 0, 4);   // e30
        add(4, 1, 0, 0, 3'b001, 0, 0, 4);   // e34
        add(1, 1, 0, 0, 3'b011, 0, 0, 4);   // e35
        add(4, 1, 0, 0, 3'b011, 0, 0, 4);   // e39
        add(1, 1, 0, 0, 3'b111, 1, 0, 5);   // e40
        add(5, 1, 0, 0, 3'b111, 1, 0, 5);   // e45
        // short lock drop ignored, long drop re-sequences
        add(2, 0, 0, 0, 3'b111, 1, 0, 5);   // e47
        add(5, 1, 0, 0, 3'b111, 1, 0, 5);   // e52
        add(3, 0, 0, 0, 3'b111, 1, 0, 5);   // e55
        add(1, 1, 0, 0, 3'b111, 1, 0, 5);   // e56
        add(1, 1, 0, 1, 3'b000, 0, 1, 1);   // e57
        add(7, 1, 0, 1, 3'b000, 0, 1, 1);   // e64
        add(1, 1, 0, 0, 3'b000, 0, 1, 2);   // e65
        add(1, 1, 0, 0, 3'b000, 0, 1, 3);   // e66
        add(15, 1, 0, 0, 3'b000, 0, 1, 3);  // e81
        add(1, 1, 0, 0, 3'b001, 0, 1, 4);   // e82
        add(10, 1, 0, 0, 3'b111, 1, 1, 5);  // e92
        // soft reset from RUN
        add(1, 1, 1, 0, 3'b000, 0, 1, 3);   // e93
        add(15, 1, 0, 0, 3'b000, 0, 1, 3);  // e108
        add(1, 1, 0, 0, 3'b001, 0, 1, 4);   // e109
        add(10, 1, 0, 0, 3'b111, 1, 1, 5);  // e119
        // one-cycle lock glitch at stable count 10
        add(1, 1, 1, 0, 3'b000, 0, 1, 3);   // e120
        add(8, 1, 0, 0, 3'b000, 0, 1, 3);   // e128
        add(1, 0, 0, 0, 3'b000, 0, 1, 3);   // e129
        add(1, 1, 0, 0, 3'b000, 0, 1, 3);   // e130
        add(6, 1, 0, 0, 3'b000, 0, 1, 3);   // e136
        add(10, 1, 0, 0, 3'b000, 0, 1, 3);  // e146
        add(1, 1, 0, 0, 3'b001, 0, 1, 4);   // e147
        add(10, 1, 0, 0, 3'b111, 1, 1, 5);  // e157
        // soft reset coincident with third low sample
        add(3, 0, 0, 0, 3'b111, 1, 1, 5);   // e160
        add(1, 1, 0, 0, 3'b111, 1, 1, 5);   // e161
        add(1, 1, 1, 1, 3'b000, 0, 2, 1);   // e162
        add(3, 1, 0, 1, 3'b000, 0, 2, 1);   // e165

        rst = 1'b1;
        pll_locked = 1'b1;
        soft_rst_en = 1'b0;
        step(3);
        chk("reset", 0, 0, 3'b000, 0, 8'd0, 3'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            pll_locked  = tbl[i].lk;
            soft_rst_en = tbl[i].sf;
            step(tbl[i].adv);
            chk("vec", i, tbl[i].pll, tbl[i].rn, tbl[i].dn, tbl[i].llc, tbl[i].st);
        end
        soft_rst_en = 1'b0;

        // lock never arrives: PLL reset re-pulses every 72 cycles
        rst = 1'b1;
        #2;
        chk("reset2", 0, 0, 3'b000, 0, 8'd0, 3'd0);
        pll_locked = 1'b0;
        step(2);
        rst = 1'b0;
        for (int e = 1; e <= 160; e++) begin
            step(1);
            cmp("nolock.rst_pll", e, rst_pll, (e >= 5) && (((e - 5) % 72) < 8));
            cmp("nolock.rst_out_n", e, rst_out_n, 3'b000);
        end

        // asynchronous reset in the middle of RELEASE
        rst = 1'b1;
        pll_locked = 1'b1;
        step(2);
        rst = 1'b0;
        step(32);
        chk("prerst", 0, 0, 3'b001, 0, 8'd0, 3'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("asyncrst", 0, 0, 3'b000, 0, 8'd0, 3'd0);
        step(1);
        chk("asyncrst", 1, 0, 3'b000, 0, 8'd0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
